// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory bus bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot access size codes as driven by the CPU.
    localparam logic [2:0] SZ_BYTE = 3'b100;
    localparam logic [2:0] SZ_HALF = 3'b010;
    localparam logic [2:0] SZ_WORD = 3'b001;

    localparam logic [31:0] DEF_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_lane_align.sv
// Size/offset decode: byte enables, store lane replication, load extraction
// and the legality (one-hot size + natural alignment) flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic        legal,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted;

    assign shifted = mem_rdata >> {off, 3'b000};

    always_comb begin
        legal     = 1'b0;
        be        = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
        case (size)
            SZ_BYTE: begin
                legal     = 1'b1;
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {24'b0, shifted[7:0]};
            end
            SZ_HALF: begin
                legal     = ~off[0];
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {16'b0, off[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
            end
            SZ_WORD: begin
                legal     = (off == 2'b00);
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = mem_rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// CPU data port to req/ack word memory bridge with PC stall.
// Optional BUSY timeout abort enabled by defining DMEM_TIMEOUT_EN.
module dmem_bus_bridge
    import dmem_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        align_err,
    output logic        timeout_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] rdata_q;

    logic        in_idle;
    logic [2:0]  la_size;
    logic [1:0]  la_off;
    logic        legal;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        start;
    logic        abort;

    // Decode from the live CPU inputs while idle, from the latched access otherwise.
    assign in_idle = (state == IDLE);
    assign la_size = in_idle ? size : size_q;
    assign la_off  = in_idle ? addr[1:0] : off_q;

    dmem_lane_align u_align (
        .size      (la_size),
        .off       (la_off),
        .wdata     (wdata),
        .mem_rdata (mem_rdata),
        .legal     (legal),
        .be        (be),
        .wdata_rep (wdata_rep),
        .rdata_ext (rdata_ext)
    );

    // Combinational outputs are gated with rst so everything reads 0 in reset.
    assign start     = rst & in_idle & cs & legal;
    assign align_err = rst & in_idle & cs & ~legal;
    assign stall     = start | (rst & (state == BUSY));
    assign rdata     = align_err ? 32'h0 : rdata_q;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] busy_cnt;

    // busy_cnt holds the number of BUSY cycles already spent without ack.
    assign abort = (state == BUSY) && !mem_ack && (busy_cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (state != BUSY) busy_cnt <= '0;
            else               busy_cnt <= busy_cnt + CNT_W'(1);
        end
    end
`else
    logic [31:0] unused_timeout_cfg;

    assign unused_timeout_cfg = TIMEOUT_CYCLES;
    assign abort              = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            size_q    <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        size_q    <= size;
                        off_q     <= addr[1:0];
                        mem_req   <= 1'b1;
                        mem_we    <= we;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= be;
                        mem_wdata <= wdata_rep;
                        state     <= BUSY;
                    end else if (align_err) begin
                        rdata_q <= '0;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata_q <= rdata_ext;
                        state <= DONE;
                    end else if (abort) begin
                        // A store that times out is simply lost.
                        mem_req <= 1'b0;
                        if (!mem_we) rdata_q <= ERR_RDATA;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Self-checking bench for dmem_bus_bridge against a byte-arithmetic reference model.
module tb_dmem_bus_bridge;

    localparam int TO = 4;
`ifdef DMEM_TIMEOUT_EN
    localparam bit HAS_TO = 1'b1;
`else
    localparam bit HAS_TO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        align_err;
    logic        timeout_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int          checks = 0;
    int          errors = 0;
    int          req_rises = 0;
    logic        req_prev = 1'b0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .cs          (cs),
        .we          (we),
        .size        (size),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .stall       (stall),
        .align_err   (align_err),
        .timeout_err (timeout_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // Counts request starts, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_req && !req_prev) req_rises++;
        req_prev = mem_req;
    end

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal_m(input logic [2:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        return (n != 0) && ((int'(a[1:0]) % n) == 0);
    endfunction

    function automatic logic [3:0] be_m(input logic [2:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        int off = int'(a[1:0]);
        logic [3:0] r = '0;
        for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
        return r;
    endfunction

    function automatic logic [31:0] wd_m(input logic [2:0] sz, input logic [31:0] wd);
        int n = nbytes(sz);
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_m(input logic [2:0] sz, input logic [31:0] a,
                                         input logic [31:0] word);
        int n = nbytes(sz);
        logic [63:0] v = {32'h0, word} >> (8 * int'(a[1:0]));
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        return 32'(v & mask);
    endfunction

    // One CPU access, cycle by cycle; ack_lat = BUSY cycle carrying the ack (0 = never).
    task automatic drive_access(input string tag, input bit w, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int ack_lat, input logic [31:0] rword);
        bit to_hit;
        int exp_busy;
        int rises0;
        to_hit   = HAS_TO && (ack_lat == 0 || ack_lat > TO);
        exp_busy = to_hit ? TO : ack_lat;
        @(negedge clk);
        cs = 1'b1; we = w; size = sz; addr = a; wdata = wd;
        mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        if (!legal_m(sz, a)) begin
            exp_rdata = 32'h0;
            checks++;
            if (align_err !== 1'b1 || stall !== 1'b0 || rdata !== 32'h0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL %s illegal: align_err=%b stall=%b rdata=%h mem_req=%b, want 1 0 0 0",
                         tag, align_err, stall, rdata, mem_req);
            end
            @(negedge clk); cs = 1'b0; #1;
            checks++;
            if (mem_req !== 1'b0 || align_err !== 1'b0 || rdata !== 32'h0) begin
                errors++;
                $display("FAIL %s illegal_after: mem_req=%b align_err=%b rdata=%h, want 0 0 0",
                         tag, mem_req, align_err, rdata);
            end
            return;
        end
        checks++;
        if (stall !== 1'b1 || align_err !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s idle: stall=%b align_err=%b mem_req=%b, want 1 0 0",
                     tag, stall, align_err, mem_req);
        end
        rises0 = req_rises;
        for (int k = 1; k <= exp_busy; k++) begin
            @(negedge clk);
            mem_ack   = (k == ack_lat);
            mem_rdata = (k == ack_lat) ? rword : $urandom;
            #1;
            checks++;
            if (mem_req !== 1'b1 || stall !== 1'b1 || mem_we !== w || timeout_err !== 1'b0 ||
                mem_addr !== {a[31:2], 2'b00} || mem_be !== be_m(sz, a) ||
                (w && mem_wdata !== wd_m(sz, wd))) begin
                errors++;
                $display("FAIL %s busy%0d: req=%b stall=%b we=%b to=%b addr=%h be=%b wd=%h, want 1 1 %b 0 %h %b %h",
                         tag, k, mem_req, stall, mem_we, timeout_err, mem_addr, mem_be, mem_wdata,
                         w, {a[31:2], 2'b00}, be_m(sz, a), wd_m(sz, wd));
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
        #1;
        if (!w) exp_rdata = to_hit ? 32'hDEAD_BEEF : rd_m(sz, a, rword);
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || rdata !== exp_rdata ||
            timeout_err !== to_hit || (req_rises - rises0) != 1) begin
            errors++;
            $display("FAIL %s done: stall=%b req=%b rdata=%h to=%b reqs=%0d, want 0 0 %h %b 1",
                     tag, stall, mem_req, rdata, timeout_err, req_rises - rises0, exp_rdata, to_hit);
        end
        // Back in IDLE: a stray ack must be ignored and nothing restarts.
        @(negedge clk);
        cs = 1'b0; mem_ack = 1'($urandom_range(0, 1));
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || rdata !== exp_rdata || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL %s after: req=%b stall=%b rdata=%h to=%b, want 0 0 %h 0",
                     tag, mem_req, stall, rdata, timeout_err, exp_rdata);
        end
        mem_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; cs = 1'b1; we = 1'b0; size = 3'b001; addr = 32'h0;
        wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        #12;
        checks++;
        if ({rdata, stall, align_err, timeout_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_state: rdata=%h stall=%b aerr=%b to=%b req=%b we=%b addr=%h be=%b wd=%h, want all 0",
                     rdata, stall, align_err, timeout_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        @(negedge clk); cs = 1'b0; rst = 1'b1;
    endtask

    task automatic test_word_load();
        drive_access("word_load", 1'b0, 3'b001, 32'h100, 32'h0, 3, 32'h1122_3344);
    endtask

    task automatic test_byte_store();
        drive_access("byte_store", 1'b1, 3'b100, 32'h203, 32'h0000_00A5, 1, 32'h0);
    endtask

    task automatic test_sub_loads();
        drive_access("half_load", 1'b0, 3'b010, 32'h302, 32'h0, 2, 32'hBEEF_1234);
        drive_access("byte_load", 1'b0, 3'b100, 32'h301, 32'h0, 1, 32'hBEEF_1234);
    endtask

    task automatic test_misaligned();
        drive_access("mis_word", 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h0);
        drive_access("mis_half", 1'b1, 3'b010, 32'h101, 32'h5555, 1, 32'h0);
        drive_access("bad_size", 1'b0, 3'b011, 32'h100, 32'h0, 1, 32'h0);
    endtask

    task automatic test_reset_mid_busy();
        drive_access("pre_rst", 1'b0, 3'b001, 32'h40, 32'h0, 1, 32'hCAFE_F00D);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; size = 3'b001; addr = 32'h80;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        exp_rdata = 32'h0;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0 || mem_addr !== 32'h0 ||
            mem_be !== 4'h0 || align_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy: req=%b stall=%b rdata=%h addr=%h be=%b aerr=%b, want all 0",
                     mem_req, stall, rdata, mem_addr, mem_be, align_err);
        end
        @(negedge clk);
        cs = 1'b0; rst = 1'b1; mem_ack = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_late_ack: req=%b stall=%b rdata=%h, want 0 0 0", mem_req, stall, rdata);
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] sz_tab [4] = '{3'b100, 3'b010, 3'b001, 3'b000};
        for (int i = 0; i < 40; i++) begin
            logic [2:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom) : sz_tab[$urandom_range(0, 2)];
            drive_access("rand", 1'($urandom), sz, $urandom, $urandom,
                         $urandom_range(1, 3), $urandom);
        end
    endtask

`ifdef DMEM_TIMEOUT_EN
    task automatic test_timeout();
        drive_access("to_load", 1'b0, 3'b001, 32'h500, 32'h0, 0, 32'h0);
        drive_access("to_ack4", 1'b0, 3'b001, 32'h504, 32'h0, TO, 32'h0BAD_CAFE);
        drive_access("to_store", 1'b1, 3'b010, 32'h506, 32'h1234, 0, 32'h0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_sub_loads();
        test_misaligned();
        test_reset_mid_busy();
`ifdef DMEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
